decs2sex_entry: RTL

- Serial two-digit decimal entry block; inverse of the binary-to-decimal digit converter.
- Accepts a tens digit, then a units digit, over a valid/ready handshake.
- Range-checks the digits and produces a 6-bit binary value (0..MAX_VALUE) for setting minute, second or hour registers.
- Sits between the front-panel digit entry logic and the time registers.

---
 rtl/decs2sex_entry_pkg.sv | 20 ++
 rtl/decs2sex.sv | 19 +
 rtl/decs2sex_entry.sv | 128 ++++++++++++
 3 files changed

// File: rtl/decs2sex_entry_pkg.sv
// Sexagesimal entry utilities: FSM state encoding and the digit/value widths
// shared by the decimal-entry block and its combinational converter.
package decs2sex_entry_pkg;

  localparam int unsigned DIGIT_MAX  = 9;
  localparam int unsigned SEX_WIDTH  = 6;
  localparam int unsigned DECS_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNITS = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= 4'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/decs2sex.sv
// Combinational decs-to-binary converter: {tens[2:0], units[3:0]} -> tens*10+units.
// Exact inverse of the binary-to-decimal digit converter.
module decs2sex
  import decs2sex_entry_pkg::*;
(
  input  logic [DECS_WIDTH-1:0] decs,
  output logic [DECS_WIDTH-1:0] bin
);

  logic [2:0] tens;
  logic [3:0] units;

  assign tens  = decs[6:4];
  assign units = decs[3:0];

  // tens*10 built as tens*8 + tens*2 so no multiplier is inferred
  assign bin = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {3'b000, units};

endmodule

// File: rtl/decs2sex_entry.sv
// Serial two-digit decimal entry: accepts tens then units over valid/ready,
// range-checks against MAX_VALUE and holds the binary result for the consumer.
module decs2sex_entry
  import decs2sex_entry_pkg::*;
#(
  parameter int unsigned MAX_VALUE = 59
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [3:0]           digit,
  input  logic                 digit_valid,
  output logic                 digit_ready,
  output logic [SEX_WIDTH-1:0] value,
  output logic                 value_valid,
  input  logic                 value_ready,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned          TENS_MAX   = MAX_VALUE / 10;
  localparam logic [3:0]           TENS_MAX_L = 4'(TENS_MAX);
  localparam logic [DECS_WIDTH-1:0] MAX_L     = DECS_WIDTH'(MAX_VALUE);

  state_e                 state_q, state_d;
  logic [2:0]             tens_q, tens_d;
  logic [DECS_WIDTH-1:0]  sum_q, sum_d;
  logic [SEX_WIDTH-1:0]   value_q, value_d;
  logic                   value_valid_q, value_valid_d;
  logic                   err_q, err_d;

  logic                   digit_xfer;
  logic                   digit_ok;
  logic [DECS_WIDTH-1:0]  units_sum;

  assign digit_ready = (state_q == IDLE) || (state_q == UNITS);
  assign busy        = (state_q != IDLE);
  assign digit_xfer  = digit_valid && digit_ready;
  assign digit_ok    = is_bcd_digit(digit);

  decs2sex u_decs2sex (
    .decs ({tens_q, digit}),
    .bin  (units_sum)
  );

  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    sum_d         = sum_q;
    value_d       = value_q;
    value_valid_d = value_valid_q;
    err_d         = 1'b0;

    // clear wins over every transition and never raises err
    if (clear) begin
      state_d       = IDLE;
      value_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (digit_xfer) begin
            if (!digit_ok || (digit > TENS_MAX_L)) begin
              err_d = 1'b1;
            end else begin
              tens_d  = digit[2:0];
              state_d = UNITS;
            end
          end
        end
        UNITS: begin
          if (digit_xfer) begin
            if (!digit_ok) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              sum_d   = units_sum;
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (sum_q > MAX_L) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            value_d       = sum_q[SEX_WIDTH-1:0];
            value_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          // value itself is left untouched after the handshake
          if (value_ready) begin
            value_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
        default: begin
          state_d       = IDLE;
          value_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tens_q        <= '0;
      sum_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      sum_q         <= sum_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign err         = err_q;

endmodule
